oct_burst_responder: RTL and testbench
======================================

OCT_BURST_RESPONDER -- requirements
Module: oct_burst_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 6: RAM depth = 2^DEPTH_LOG2 words of 256 bits.
REQ-002 Parameter MAX_BURST, default 8: largest legal burstcount, range 1..15.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 slave_address  input  25  word address; only bits [DEPTH_LOG2-1:0] used.
REQ-006 slave_burstcount  input  4  beats in the burst, sampled on the first beat only.
REQ-007 slave_byteenable  input  32  per-byte write enable, bit i covers writedata[8i+7:8i].
REQ-008 slave_read  input  1  read request.
REQ-009 slave_write  input  1  write request / write beat.
REQ-010 slave_writedata  input  256  write data.
REQ-011 slave_waitrequest  output  1  high = current request not accepted.
REQ-012 slave_readdata  output  256  read data, qualified by slave_readdatavalid.
REQ-013 slave_readdatavalid  output  1  one pulse per read beat.
REQ-014 slave_endofpacket  output  1  high with the last readdatavalid beat of a burst.
REQ-015 protocol_err  output  1  sticky error flag; cleared only by reset.

Function
REQ-016 States SHALL be IDLE, WR_BURST, RD_BURST; single-port-style RAM with 1-cycle registered read.
REQ-017 slave_waitrequest SHALL be 0 in IDLE and WR_BURST, 1 in RD_BURST, 1 while reset_n low.
REQ-018 IDLE + slave_write: accept beat 1; write RAM[address] per byteenable; latch addr+1, remaining = burstcount-1; go WR_BURST if remaining > 0, else stay IDLE.
REQ-019 WR_BURST: each cycle with slave_write high writes RAM[addr] per byteenable, addr+1, remaining-1; cycles with slave_write low hold all state; after the last beat go IDLE.
REQ-020 IDLE + slave_read (no write): accept; latch address, count = burstcount; go RD_BURST next cycle.
REQ-021 RD_BURST: one RAM read per cycle at addr, addr+1, ...; after count reads go IDLE.
REQ-022 Read latency: first readdatavalid exactly 2 cycles after the accepting edge; following beats back-to-back, one per cycle, no gaps.
REQ-023 slave_endofpacket SHALL be 1 only on the cycle of the final read beat of a burst; 0 otherwise.
REQ-024 Address arithmetic SHALL wrap modulo 2^DEPTH_LOG2 within a burst.
REQ-025 burstcount 0 or > MAX_BURST: set protocol_err; execute as a burst of 1.
REQ-026 slave_read and slave_write both high in IDLE: perform the write only; drop the read; set protocol_err.
REQ-027 slave_read high in WR_BURST: ignore it; set protocol_err; the write burst continues.
REQ-028 A new command SHALL be accepted in the IDLE cycle that carries the final readdatavalid of the preceding burst.
REQ-029 Read of a word written in the immediately preceding cycle SHALL return the new data.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, slave_readdatavalid 0, slave_endofpacket 0, protocol_err 0, slave_readdata 0, and counters and latched address 0.
REQ-031 Reset mid-burst SHALL abort the burst with no further writes or read beats; RAM contents are undefined after reset.
REQ-032 After reset_n rises, the first command SHALL be accepted on the first clock edge.

Verification
REQ-033 Write burst of 4 at address 0x10, data D0..D3, byteenable all ones -> 4 beats accepted with waitrequest 0; read burst 4 at 0x10 returns D0..D3 on 4 consecutive cycles, first beat 2 cycles after accept, endofpacket on D3 only.
REQ-034 Write 0xFF.. to address 5, then write 0x00.. with byteenable 0x0000_0001 -> a read of address 5 returns 0xFF..FF00.
REQ-035 DEPTH_LOG2=6, write burst 3 at address 62 -> words land at 62, 63, 0; a read burst of 3 at 62 returns them in order.
REQ-036 Read burst burstcount 0, then burstcount 9 -> protocol_err rises and stays 1; each returns exactly one beat with endofpacket.
REQ-037 Assert reset_n low on the 2nd read beat of a burst of 8 -> readdatavalid 0 immediately with no further beats; waitrequest 0 on the first edge after release.
REQ-038 Back-to-back read bursts of 2 and 2 -> 4 consecutive beats with a one-cycle gap at most, endofpacket on beats 2 and 4.

Source files
------------

// File: rtl/oct_burst_responder.sv
// Burst-capable 256-bit slave backed by a single-port RAM with a registered read port.
// Reads return after two cycles; writes are accepted at full rate.
module oct_burst_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int MAX_BURST  = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [24:0]  slave_address,
  input  logic [3:0]   slave_burstcount,
  input  logic [31:0]  slave_byteenable,
  input  logic         slave_read,
  input  logic         slave_write,
  input  logic [255:0] slave_writedata,
  output logic         slave_waitrequest,
  output logic [255:0] slave_readdata,
  output logic         slave_readdatavalid,
  output logic         slave_endofpacket,
  output logic         protocol_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] MAXB   = 4'(MAX_BURST);

  typedef logic [DEPTH_LOG2-1:0] addr_t;

  logic [1:0]   state_q, state_d;
  addr_t        addr_q, addr_d, wr_addr;
  logic [3:0]   cnt_q, cnt_d, bc_eff;
  logic         err_q, err_d;
  logic         bc_bad, wr_en, rd_en;
  logic         rd_vld_q, rd_eop_q, vld_q, eop_q;
  logic [255:0] ram_q, rdata_q;
  logic [255:0] mem [DEPTH];
  logic         addr_unused;

  assign addr_unused = ^slave_address[24:DEPTH_LOG2];

  // Illegal burst lengths run as single-beat bursts.
  assign bc_bad = (slave_burstcount == 4'd0) || (slave_burstcount > MAXB);
  assign bc_eff = bc_bad ? 4'd1 : slave_burstcount;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = addr_q;
    case (state_q)
      S_IDLE: begin
        if (slave_write) begin
          // A simultaneous read is dropped; the write wins.
          wr_en   = 1'b1;
          wr_addr = slave_address[DEPTH_LOG2-1:0];
          addr_d  = wr_addr + 1'b1;
          cnt_d   = bc_eff - 4'd1;
          if (bc_bad || slave_read) err_d = 1'b1;
          if (cnt_d != 4'd0) state_d = S_WR;
        end else if (slave_read) begin
          addr_d  = slave_address[DEPTH_LOG2-1:0];
          cnt_d   = bc_eff;
          if (bc_bad) err_d = 1'b1;
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (slave_read) err_d = 1'b1;
        if (slave_write) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_IDLE;
        end
      end
      S_RD: begin
        rd_en  = 1'b1;
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_eop_q <= 1'b0;
      vld_q    <= 1'b0;
      eop_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_vld_q <= rd_en;
      rd_eop_q <= rd_en && (cnt_q == 4'd1);
      vld_q    <= rd_vld_q;
      eop_q    <= rd_eop_q;
      if (rd_vld_q) rdata_q <= ram_q;
    end
  end

  // RAM has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && reset_n) begin
      for (int b = 0; b < 32; b++) begin
        if (slave_byteenable[b]) mem[wr_addr][8*b +: 8] <= slave_writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[addr_q];
  end

  assign slave_waitrequest   = !reset_n || (state_q == S_RD);
  assign slave_readdata      = rdata_q;
  assign slave_readdatavalid = vld_q;
  assign slave_endofpacket   = eop_q;
  assign protocol_err        = err_q;

endmodule

// File: tb/tb_oct_burst_responder.sv
// Directed bench for oct_burst_responder: stimulus pushes expected read beats,
// a negedge monitor pops and checks data, end-of-packet and arrival cycle.
module tb_oct_burst_responder;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [24:0]  slave_address = '0;
  logic [3:0]   slave_burstcount = '0;
  logic [31:0]  slave_byteenable = '0;
  logic         slave_read = 1'b0;
  logic         slave_write = 1'b0;
  logic [255:0] slave_writedata = '0;
  logic         slave_waitrequest;
  logic [255:0] slave_readdata;
  logic         slave_readdatavalid;
  logic         slave_endofpacket;
  logic         protocol_err;

  oct_burst_responder #(.DEPTH_LOG2(6), .MAX_BURST(8)) dut (
    .clk(clk), .reset_n(reset_n), .slave_address(slave_address),
    .slave_burstcount(slave_burstcount), .slave_byteenable(slave_byteenable),
    .slave_read(slave_read), .slave_write(slave_write), .slave_writedata(slave_writedata),
    .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid), .slave_endofpacket(slave_endofpacket),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [255:0] d; logic eop; int at; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [255:0] mdl [64];
  localparam logic [31:0] BE_ALL = 32'hFFFF_FFFF;

  function automatic logic [255:0] dpat(int k);
    return {8{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every presented read beat must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && slave_readdatavalid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_beat: got data %h at cycle %0d want no beat", slave_readdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", slave_readdata, e.d);
        chk("rd_eop", {255'b0, slave_endofpacket}, {255'b0, e.eop});
        chk("rd_cycle", 256'(cyc), 256'(e.at));
      end
    end
  end

  task automatic idle_bus();
    slave_read = 1'b0; slave_write = 1'b0;
  endtask

  task automatic wbeat(input int a, input logic [3:0] bc, input logic [255:0] d,
                       input logic [31:0] be, input logic rd = 1'b0);
    slave_address = 25'(a); slave_burstcount = bc; slave_byteenable = be;
    slave_writedata = d; slave_write = 1'b1; slave_read = rd;
    chk("wr_waitreq", {255'b0, slave_waitrequest}, 256'd0);
    @(posedge clk); #1;
    for (int b = 0; b < 32; b++) if (be[b]) mdl[a % 64][8*b +: 8] = d[8*b +: 8];
    idle_bus();
  endtask

  task automatic wburst(input int a, input int n, input int seed);
    for (int i = 0; i < n; i++) wbeat((a + i) % 64, 4'(n), dpat(seed + i), BE_ALL);
  endtask

  task automatic rcmd(input int a, input logic [3:0] bc, input int nb, output int acc,
                      input bit use_x = 1'b0, input logic [255:0] x = '0);
    int t = 0;
    while (slave_waitrequest && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL rd_accept_timeout: waitrequest still %b want 0", slave_waitrequest);
    end
    slave_address = 25'(a); slave_burstcount = bc; slave_read = 1'b1; slave_write = 1'b0;
    @(posedge clk); #1;
    acc = cyc;
    idle_bus();
    for (int i = 0; i < nb; i++) begin
      exp_t e;
      e.d = use_x ? x : mdl[(a + i) % 64];
      e.eop = (i == nb - 1);
      e.at = acc + 2 + i;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 40) begin @(posedge clk); t++; end
    n_cmp++;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats outstanding want 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0; #1;
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc2;
    #1;
    chk("rst_waitreq", {255'b0, slave_waitrequest}, 256'd1);
    chk("rst_valid", {255'b0, slave_readdatavalid}, 256'd0);
    chk("rst_eop", {255'b0, slave_endofpacket}, 256'd0);
    chk("rst_err", {255'b0, protocol_err}, 256'd0);
    chk("rst_rdata", slave_readdata, 256'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; #1;
    chk("rel_waitreq", {255'b0, slave_waitrequest}, 256'd0);

    // Write burst 4 then read it back.
    wburst(16, 4, 0);
    rcmd(16, 4'd4, 4, acc);
    drain();

    // Byte-enable merge.
    wbeat(5, 4'd1, {256{1'b1}}, BE_ALL);
    wbeat(5, 4'd1, 256'd0, 32'h0000_0001);
    rcmd(5, 4'd1, 1, acc, 1'b1, {{31{8'hFF}}, 8'h00});
    drain();

    // Address wrap.
    wburst(62, 3, 10);
    rcmd(62, 4'd3, 3, acc);
    drain();

    // Back-to-back reads.
    rcmd(16, 4'd2, 2, acc);
    rcmd(18, 4'd2, 2, acc2);
    chk("b2b_spacing_le4", 256'(acc2 - acc <= 4), 256'd1);
    drain();

    // Read immediately after write.
    wbeat(20, 4'd1, dpat(99), BE_ALL);
    rcmd(20, 4'd1, 1, acc, 1'b1, dpat(99));
    drain();
    chk("err_clean", {255'b0, protocol_err}, 256'd0);

    // Illegal burst counts.
    rcmd(16, 4'd0, 1, acc);
    drain();
    chk("err_bc0", {255'b0, protocol_err}, 256'd1);
    rcmd(17, 4'd9, 1, acc);
    drain();
    chk("err_bc9_sticky", {255'b0, protocol_err}, 256'd1);

    // Reset on the second beat of an 8-beat read.
    rcmd(16, 4'd8, 8, acc);
    repeat (3) @(posedge clk);
    #2;
    chk("beat2_valid", {255'b0, slave_readdatavalid}, 256'd1);
    reset_n = 1'b0; #1;
    q.delete();
    chk("midrst_valid", {255'b0, slave_readdatavalid}, 256'd0);
    chk("midrst_eop", {255'b0, slave_endofpacket}, 256'd0);
    chk("midrst_err", {255'b0, protocol_err}, 256'd0);
    chk("midrst_waitreq", {255'b0, slave_waitrequest}, 256'd1);
    repeat (3) @(posedge clk);
    #1;
    slave_address = 25'd7; slave_burstcount = 4'd1; slave_byteenable = BE_ALL;
    slave_writedata = dpat(77); slave_write = 1'b1;
    reset_n = 1'b1; #1;
    chk("post_rst_waitreq", {255'b0, slave_waitrequest}, 256'd0);
    @(posedge clk); #1;
    mdl[7] = dpat(77);
    idle_bus();
    rcmd(7, 4'd1, 1, acc);
    drain();

    // Read and write together: write only, error flagged.
    chk("err_after_rst", {255'b0, protocol_err}, 256'd0);
    wbeat(30, 4'd1, dpat(55), BE_ALL, 1'b1);
    chk("err_rw_both", {255'b0, protocol_err}, 256'd1);
    repeat (4) @(posedge clk);
    #1;
    rcmd(30, 4'd1, 1, acc);
    drain();

    // Read during write burst, plus a stalled beat.
    pulse_reset();
    chk("err_cleared", {255'b0, protocol_err}, 256'd0);
    wbeat(40, 4'd3, dpat(200), BE_ALL);
    wbeat(41, 4'd3, dpat(201), BE_ALL, 1'b1);
    @(posedge clk); #1;
    wbeat(42, 4'd3, dpat(202), BE_ALL);
    chk("err_rd_in_wr", {255'b0, protocol_err}, 256'd1);
    rcmd(40, 4'd3, 3, acc);
    drain();

    chk("queue_empty", 256'(q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
